// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that owns the PC, issues word reads to instruction
// memory (valid/ready request, in-order response), buffers returned words in a
// prefetch FIFO and presents {instr, instr_pc, instr_fault} to decode.
// Ports:
//   clk, reset_n                  clock / asynchronous active-low reset
//   redirect_valid, redirect_pc   branch/jump redirect (flushes FIFO, drops in-flight data)
//   imem_req_valid/addr/ready     word read request channel
//   imem_rsp_valid/data           read response channel (strictly in request order)
//   instr_valid/instr/instr_pc    FIFO head toward decode
//   instr_fault                   head is a misaligned-redirect fault entry (instr = NOP)
//   instr_ready                   decode accepts head
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]           fetch_pc;
  logic                  halted;
  logic [CW-1:0]         outstanding;   // all requests in flight, live or to be dropped
  logic [CW-1:0]         discard;       // in-flight responses still to be dropped
  logic [CW-1:0]         fifo_count;
  logic [31:0]           fifo_instr [FIFO_DEPTH];
  logic [31:0]           fifo_pc    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_fault;
  logic [31:0]           tag_q      [FIFO_DEPTH];
  logic [PW-1:0]         tag_wr;
  logic [PW-1:0]         tag_rd;

  logic          req_fire;
  logic          rsp_take;
  logic          rsp_live;
  logic          pop;
  logic          misaligned;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] count_nxt;

  // Credit-based request issue and handshake decode
  always_comb begin
    imem_req_valid = reset_n && !halted && !redirect_valid &&
                     ((SW'(fifo_count) + SW'(outstanding)) < SW'(FIFO_DEPTH));
    req_fire   = imem_req_valid && imem_req_ready;
    rsp_take   = imem_rsp_valid && (outstanding != '0);
    rsp_live   = rsp_take && (discard == '0);
    pop        = instr_valid && instr_ready;
    misaligned = (redirect_pc[1:0] != 2'b00);
    // Slot index accounts for a same-cycle pop shifting the FIFO down
    wr_idx     = fifo_count - CW'(pop);
    count_nxt  = fifo_count + CW'(rsp_live) - CW'(pop);
  end

  assign imem_req_addr = fetch_pc;
  assign instr         = fifo_instr[0];
  assign instr_pc      = fifo_pc[0];
  assign instr_fault   = fifo_fault[0];

  // PC, credit counters and FIFO occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      halted      <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      instr_valid <= 1'b0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream
      fetch_pc    <= redirect_pc;
      halted      <= misaligned;
      outstanding <= outstanding - CW'(rsp_take);
      discard     <= outstanding - CW'(rsp_take);
      fifo_count  <= CW'(misaligned);
      instr_valid <= misaligned;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wr   <= tag_wr + PW'(1);
      end
      if (rsp_live) tag_rd <= tag_rd + PW'(1);
      if (rsp_take && !rsp_live) discard <= discard - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      fifo_count  <= count_nxt;
      instr_valid <= (count_nxt != '0);
    end
  end

  // PC tags of live requests, consumed in response order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) tag_q[i] <= '0;
    end else if (req_fire) begin
      tag_q[tag_wr] <= fetch_pc;
    end
  end

  // Shift-register prefetch FIFO; entry 0 drives the decode outputs directly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
      fifo_fault <= '0;
    end else if (redirect_valid) begin
      fifo_fault <= FIFO_DEPTH'(misaligned);
      if (misaligned) begin
        fifo_instr[0] <= NOP;
        fifo_pc[0]    <= redirect_pc;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          fifo_instr[i] <= fifo_instr[i+1];
          fifo_pc[i]    <= fifo_pc[i+1];
        end
        fifo_fault <= fifo_fault >> 1;
      end
      if (rsp_live) begin
        fifo_instr[PW'(wr_idx)] <= imem_rsp_data;
        fifo_pc[PW'(wr_idx)]    <= tag_q[tag_rd];
        fifo_fault[PW'(wr_idx)] <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Delivery and decode-starvation counters; survive redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid && !redirect_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: in-order memory model with random ready/latency,
// reference model of the expected delivered instruction stream and request addresses.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_fault(instr_fault), .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_req = 0;
  int n_pop = 0;
  int mem_rdy_pct = 100;
  int dec_rdy_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  bit stray = 1'b0;

  // Reference model: next expected delivery and next expected request address
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_fault;
  bit          m_dead;
  bit          m_halted;
  logic [31:0] tb_fetched;
  logic [31:0] tb_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_req_addr = 32'h0;
    m_fault = 1'b0; m_dead = 1'b0; m_halted = 1'b0;
    tb_fetched = '0; tb_stall = '0;
  endtask

  // Asynchronous reset assertion away from the clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_fault", 32'(instr_fault), 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at negedge, check and update model, edge follows
  task automatic tick(input logic redir, input logic [31:0] rpc);
    logic rv;
    logic took;
    logic acc;
    mreq_t e;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < 32'(mem_rdy_pct));
    instr_ready    = ($urandom_range(99) < 32'(dec_rdy_pct));
    rv = 1'b0; took = 1'b0;
    imem_rsp_data = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1; took = 1'b1;
      imem_rsp_data = mem_word(mq[0].pc);
    end else if (stray) begin
      rv = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
      stray = 1'b0;
    end
    imem_rsp_valid = rv;
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, tb_fetched);
    chk("perf_stall", perf_stall, tb_stall);
`endif
    if (redir) chk("req_in_redirect", 32'(imem_req_valid), 32'd0);
    else if (m_halted) chk("req_while_halted", 32'(imem_req_valid), 32'd0);
    acc = imem_req_valid && imem_req_ready;
    if (took) void'(mq.pop_front());
    if (acc) begin
      chk("req_addr", imem_req_addr, m_req_addr);
      e.pc  = imem_req_addr;
      e.due = cyc + int'($urandom_range(lat_max, lat_min));
      mq.push_back(e);
      m_req_addr = m_req_addr + 32'd4;
      n_req++;
    end
    chk("inflight_bound", 32'(mq.size() <= int'(DEPTH)), 32'd1);
    if (!redir && instr_valid) begin
      if (m_dead) begin
        chk("valid_after_fault", 32'(instr_valid), 32'd0);
      end else if (instr_ready) begin
        chk("pop_pc", instr_pc, m_pc);
        chk("pop_instr", instr, m_fault ? 32'h0000_0013 : mem_word(m_pc));
        chk("pop_fault", 32'(instr_fault), 32'(m_fault));
        if (m_fault) begin
          m_dead = 1'b1; m_fault = 1'b0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
        n_pop++;
      end
    end
    if (instr_valid && instr_ready) tb_fetched = tb_fetched + 32'd1;
    if (instr_ready && !instr_valid && !redir) tb_stall = tb_stall + 32'd1;
    if (redir) begin
      m_pc = rpc; m_req_addr = rpc; m_dead = 1'b0;
      m_fault  = (rpc[1:0] != 2'b00);
      m_halted = m_fault;
    end
    cyc++;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      tick(1'b0, 32'h0);
      if (instr_valid) break;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    int r0;
    int p0;
    logic [31:0] rpc;
    model_reset();

    // 1: zero-wait memory, one instruction per cycle after 2-cycle latency
    do_reset();
    stray = 1'b1;  // late response with nothing outstanding must be ignored
    mem_rdy_pct = 100; dec_rdy_pct = 100; lat_min = 1; lat_max = 1;
    tick(1'b0, 32'h0); chk("t1_iv_c0", 32'(instr_valid), 32'd0);
    tick(1'b0, 32'h0); chk("t1_iv_c1", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0);
      chk("t1_iv", 32'(instr_valid), 32'd1);
      chk("t1_pc", instr_pc, 32'(k * 4));
    end

    // 2: decode stalled -> FIFO_DEPTH requests then stop; drain, resume at 0x10
    do_reset();
    dec_rdy_pct = 0;
    r0 = n_req;
    repeat (8) tick(1'b0, 32'h0);
    chk("t2_req_count", 32'(n_req - r0), 32'(DEPTH));
    chk("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
    chk("t2_next_addr", imem_req_addr, 32'h10);
    dec_rdy_pct = 100;
    p0 = n_pop;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0);
      chk("t2_drain_iv", 32'(instr_valid), 32'd1);
    end
    chk("t2_pops", 32'(n_pop - p0), 32'd4);
    wait_valid("t2_resume_timeout", 20);
    chk("t2_resume_pc", instr_pc, 32'h10);

    // 3: three requests in flight, redirect drops their data
    do_reset();
    dec_rdy_pct = 0; lat_min = 10; lat_max = 10;
    repeat (3) tick(1'b0, 32'h0);
    chk("t3_inflight", 32'(mq.size()), 32'd3);
    mem_rdy_pct = 0;
    tick(1'b1, 32'h100);
    mem_rdy_pct = 100; dec_rdy_pct = 100; lat_min = 1; lat_max = 1;
    wait_valid("t3_timeout", 40);
    chk("t3_pc", instr_pc, 32'h100);
    chk("t3_instr", instr, mem_word(32'h100));

    // 4: redirect in the same cycle as the only outstanding response
    do_reset();
    dec_rdy_pct = 0; lat_min = 2; lat_max = 2;
    tick(1'b0, 32'h0);
    mem_rdy_pct = 0;
    tick(1'b0, 32'h0);
    chk("t4_rsp_due", 32'(mq.size() == 1 && mq[0].due == cyc), 32'd1);
    tick(1'b1, 32'h300);
    chk("t4_rsp_taken", 32'(mq.size()), 32'd0);
    mem_rdy_pct = 100; dec_rdy_pct = 100; lat_min = 1; lat_max = 1;
    wait_valid("t4_timeout", 20);
    chk("t4_pc", instr_pc, 32'h300);

    // 5: misaligned redirect -> single fault entry, fetch halted until redirect
    dec_rdy_pct = 0;
    tick(1'b1, 32'h102);
    tick(1'b0, 32'h0);
    chk("t5_iv", 32'(instr_valid), 32'd1);
    chk("t5_fault", 32'(instr_fault), 32'd1);
    chk("t5_instr", instr, 32'h0000_0013);
    chk("t5_pc", instr_pc, 32'h102);
    chk("t5_no_req", 32'(imem_req_valid), 32'd0);
    dec_rdy_pct = 100;
    tick(1'b0, 32'h0);
    repeat (5) begin
      tick(1'b0, 32'h0);
      chk("t5_empty", 32'(instr_valid), 32'd0);
      chk("t5_halted", 32'(imem_req_valid), 32'd0);
    end
    tick(1'b1, 32'h200);
    wait_valid("t5_timeout", 20);
    chk("t5_resume_pc", instr_pc, 32'h200);

    // Random traffic, redirects (aligned, misaligned, near wrap) and a mid-run reset
    mem_rdy_pct = 70; dec_rdy_pct = 60; lat_min = 1; lat_max = 3;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        stray = 1'b1;
      end
      if ($urandom_range(99) < 4) begin
        rpc = $urandom;
        case ($urandom_range(9))
          0, 1:    rpc[1:0] = 2'(1 + $urandom_range(2));
          2:       rpc = 32'hFFFF_FFF0;
          default: rpc[1:0] = 2'b00;
        endcase
        tick(1'b1, rpc);
      end else begin
        tick(1'b0, 32'h0);
      end
    end
    chk("random_progress", 32'(n_pop - p0 > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
